// File: rtl/roll_scheduler_if.sv
// Handshake bundle between the roll scheduler and its surroundings.
// The key/LFSR side drives start, stop and rand. The scheduler returns status, value and history.
interface roll_scheduler_if #(
    parameter int DATA_W     = 4,
    parameter int HIST_DEPTH = 4
);
    logic                         i_start;
    logic                         i_stop;
    logic [DATA_W-1:0]            i_rand;
    logic                         o_lfsr_step;
    logic                         o_busy;
    logic [DATA_W-1:0]            o_value;
    logic                         o_done;
    logic [7:0]                   o_step_idx;
    logic [HIST_DEPTH*DATA_W-1:0] o_hist;

    modport master (
        output i_start, i_stop, i_rand,
        input  o_lfsr_step, o_busy, o_value, o_done, o_step_idx, o_hist
    );

    modport slave (
        input  i_start, i_stop, i_rand,
        output o_lfsr_step, o_busy, o_value, o_done, o_step_idx, o_hist
    );
endinterface

// File: rtl/roll_scheduler.sv
// Roll scheduler: issues NUM_STEPS LFSR step pulses on a decelerating tick schedule.
// It latches the LFSR value after each step and keeps a history of final results.
module roll_scheduler #(
    parameter int TICK_DIV   = 2097152,
    parameter int NUM_STEPS  = 10,
    parameter int HIST_DEPTH = 4,
    parameter int DATA_W     = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    roll_scheduler_if.slave bus
);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW   = HIST_DEPTH * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STEP  = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t            r_state;
    logic [PS_W-1:0]   r_presc;
    logic [7:0]        r_tick_cnt;
    logic [7:0]        r_step_idx;
    logic              r_stop_req;
    logic [DATA_W-1:0] r_value;
    logic [HW-1:0]     r_hist;
    logic              r_done;

    state_t            w_state_nxt;
    logic [PS_W-1:0]   w_presc_nxt;
    logic [7:0]        w_tick_cnt_nxt;
    logic [7:0]        w_step_idx_nxt;
    logic              w_stop_req_nxt;
    logic [DATA_W-1:0] w_value_nxt;
    logic [HW-1:0]     w_hist_nxt;
    logic              w_done_nxt;

    logic              w_tick;
    logic [8:0]        w_tick_inc;
    logic [8:0]        w_tick_target;
    logic [7:0]        w_idx_inc;
    logic              w_last;

    // The prescaler only runs during a roll, so a tick is meaningful outside IDLE only.
    assign w_tick        = (r_state != S_IDLE) && (r_presc == PS_W'(TICK_DIV - 1));
    assign w_tick_inc    = {1'b0, r_tick_cnt} + 9'd1;
    assign w_tick_target = {1'b0, r_step_idx} + 9'd1;
    assign w_idx_inc     = r_step_idx + 8'd1;
    // An i_stop arriving during LATCH still ends the roll at this LATCH.
    assign w_last        = (w_idx_inc == 8'(NUM_STEPS)) || r_stop_req || bus.i_stop;

    always_comb begin
        w_state_nxt    = r_state;
        w_presc_nxt    = r_presc;
        w_tick_cnt_nxt = r_tick_cnt;
        w_step_idx_nxt = r_step_idx;
        w_stop_req_nxt = r_stop_req;
        w_value_nxt    = r_value;
        w_hist_nxt     = r_hist;
        w_done_nxt     = 1'b0;

        if (r_state != S_IDLE) begin
            w_presc_nxt = w_tick ? '0 : r_presc + PS_W'(1);
            if (bus.i_stop) begin
                w_stop_req_nxt = 1'b1;
            end
        end

        unique case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt    = S_WAIT;
                    w_presc_nxt    = '0;
                    w_tick_cnt_nxt = '0;
                    w_step_idx_nxt = '0;
                    w_stop_req_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                if (w_tick) begin
                    w_tick_cnt_nxt = w_tick_inc[7:0];
                    if (w_tick_inc == w_tick_target) begin
                        w_state_nxt = S_STEP;
                    end
                end
            end
            S_STEP: begin
                w_tick_cnt_nxt = '0;
                w_state_nxt    = S_LATCH;
            end
            S_LATCH: begin
                w_value_nxt    = bus.i_rand;
                w_step_idx_nxt = w_idx_inc;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_hist_nxt  = (r_hist << DATA_W) | HW'(bus.i_rand);
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_tick_cnt <= '0;
            r_step_idx <= '0;
            r_stop_req <= 1'b0;
            r_value    <= '0;
            r_hist     <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_step_idx <= w_step_idx_nxt;
            r_stop_req <= w_stop_req_nxt;
            r_value    <= w_value_nxt;
            r_hist     <= w_hist_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.o_busy      = (r_state != S_IDLE);
    assign bus.o_lfsr_step = (r_state == S_STEP);
    assign bus.o_value     = r_value;
    assign bus.o_done      = r_done;
    assign bus.o_step_idx  = r_step_idx;
    assign bus.o_hist      = r_hist;
endmodule

// File: tb/tb_roll_scheduler.sv
// Bench for roll_scheduler: one three-step and one single-step instance.
// Every cycle of each roll is compared against a closed-form schedule model.
module tb_roll_scheduler;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    roll_scheduler_if #(.DATA_W(4), .HIST_DEPTH(4)) bus0 ();
    roll_scheduler_if #(.DATA_W(4), .HIST_DEPTH(4)) bus1 ();

    roll_scheduler #(.TICK_DIV(D), .NUM_STEPS(3), .HIST_DEPTH(4), .DATA_W(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0));
    roll_scheduler #(.TICK_DIV(D), .NUM_STEPS(1), .HIST_DEPTH(4), .DATA_W(4)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1));

    // Model of the architecturally visible state kept between rolls.
    logic [3:0]  m_val  [2];
    logic [15:0] m_hist [2];
    int          m_idx  [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int inst, input logic st, input logic sp,
                         input logic [3:0] rv, input logic rs);
        bus0.i_start = (inst == 0) && st;
        bus1.i_start = (inst == 1) && st;
        bus0.i_stop  = sp;
        bus1.i_stop  = sp;
        bus0.i_rand  = rv;
        bus1.i_rand  = rv;
        rst          = rs;
    endtask

    task automatic check_outputs(input int inst, input int c, input logic [31:0] e_busy,
                                 input logic [31:0] e_step, input logic [31:0] e_done,
                                 input logic [31:0] e_val, input logic [31:0] e_idx,
                                 input logic [31:0] e_hist);
        string sfx;
        sfx = $sformatf("i%0d c%0d", inst, c);
        if (inst == 0) begin
            chk({"busy ", sfx}, 32'(bus0.o_busy), e_busy);
            chk({"step ", sfx}, 32'(bus0.o_lfsr_step), e_step);
            chk({"done ", sfx}, 32'(bus0.o_done), e_done);
            chk({"value ", sfx}, 32'(bus0.o_value), e_val);
            chk({"idx ", sfx}, 32'(bus0.o_step_idx), e_idx);
            chk({"hist ", sfx}, 32'(bus0.o_hist), e_hist);
        end else begin
            chk({"busy ", sfx}, 32'(bus1.o_busy), e_busy);
            chk({"step ", sfx}, 32'(bus1.o_lfsr_step), e_step);
            chk({"done ", sfx}, 32'(bus1.o_done), e_done);
            chk({"value ", sfx}, 32'(bus1.o_value), e_val);
            chk({"idx ", sfx}, 32'(bus1.o_step_idx), e_idx);
            chk({"hist ", sfx}, 32'(bus1.o_hist), e_hist);
        end
    endtask

    function automatic logic [3:0] pick(input int rmode, input int c);
        if (rmode == -2) return 4'(c % 16);
        if (rmode == -1) return 4'($urandom_range(15, 0));
        return 4'(rmode);
    endfunction

    // One roll started at cycle 0. s: stop cycle, x: extra start cycle, r: reset cycle (-1 = none).
    // rmode: -2 = cycle mod 16, -1 = random, else constant. sw: stop together with start.
    task automatic run_roll(input int inst, input int s, input int x, input int r,
                            input int rmode, input logic sw);
        int         n, p, e, l, e_idx;
        int         lat [1:3];
        logic [3:0] rv  [0:63];
        logic       e_step;
        logic [3:0] e_val;
        logic [15:0] e_hist;

        n = (inst == 0) ? 3 : 1;
        // Step k fires at tick k(k+1)/2. Ticks land every D cycles, the step one cycle later,
        // and the latch one cycle after that.
        for (int k = 1; k <= n; k++) lat[k] = D * k * (k + 1) / 2 + 2;
        p = n;
        for (int k = n; k >= 1; k--) if (s >= 1 && s <= lat[k]) p = k;
        e = lat[p] + 1;
        l = (r >= 0) ? r + 5 : e + 2;

        @(negedge clk);
        check_outputs(inst, 0, 0, 0, 0, 32'(m_val[inst]), 32'(m_idx[inst]), 32'(m_hist[inst]));
        rv[0] = pick(rmode, 0);
        drive(inst, 1'b1, sw, rv[0], 1'b0);

        for (int c = 1; c <= l; c++) begin
            @(negedge clk);
            if (r >= 0 && c > r) begin
                check_outputs(inst, c, 0, 0, 0, 0, 0, 0);
            end else begin
                e_step = 1'b0;
                e_idx  = 0;
                for (int k = 1; k <= p; k++) begin
                    if (c == lat[k] - 1) e_step = 1'b1;
                    if (lat[k] < c) e_idx++;
                end
                e_val  = (e_idx > 0) ? rv[lat[e_idx]] : m_val[inst];
                e_hist = (c >= e) ? {m_hist[inst][11:0], rv[lat[p]]} : m_hist[inst];
                check_outputs(inst, c, 32'(c <= lat[p]), 32'(e_step), 32'(c == e),
                              32'(e_val), 32'(e_idx), 32'(e_hist));
            end
            rv[c] = pick(rmode, c);
            drive(inst, c == x, c == s, rv[c], c == r);
        end
        drive(inst, 1'b0, 1'b0, 4'd0, 1'b0);

        if (r >= 0) begin
            for (int i = 0; i < 2; i++) begin
                m_val[i]  = '0;
                m_hist[i] = '0;
                m_idx[i]  = 0;
            end
        end else begin
            m_val[inst]  = rv[lat[p]];
            m_hist[inst] = {m_hist[inst][11:0], rv[lat[p]]};
            m_idx[inst]  = p;
        end
    endtask

    initial begin
        int s;
        for (int i = 0; i < 2; i++) begin
            m_val[i]  = '0;
            m_hist[i] = '0;
            m_idx[i]  = 0;
        end
        drive(0, 1'b0, 1'b0, 4'd0, 1'b1);
        repeat (3) @(negedge clk);
        check_outputs(0, -1, 0, 0, 0, 0, 0, 0);
        check_outputs(1, -1, 0, 0, 0, 0, 0, 0);
        drive(0, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);

        // Nominal roll with i_rand = cycle mod 16.
        run_roll(0, -1, -1, -1, -2, 1'b0);
        chk("nominal final value", 32'(bus0.o_value), 32'd10);

        // History fill and overflow.
        for (int v = 1; v <= 4; v++) run_roll(0, -1, -1, -1, v, 1'b0);
        chk("hist 1234", 32'(bus0.o_hist), 32'h1234);
        run_roll(0, -1, -1, -1, 5, 1'b0);
        chk("hist 2345", 32'(bus0.o_hist), 32'h2345);

        // Early stop in WAIT and a stop coinciding with the first LATCH.
        run_roll(0, 9, -1, -1, -1, 1'b0);
        chk("early stop idx", 32'(bus0.o_step_idx), 32'd2);
        run_roll(0, 6, -1, -1, -1, 1'b0);
        chk("stop at latch idx", 32'(bus0.o_step_idx), 32'd1);

        // Start while busy, then start and stop together in IDLE.
        run_roll(0, -1, 10, -1, -1, 1'b0);
        run_roll(0, -1, -1, -1, -1, 1'b1);
        chk("start+stop idx", 32'(bus0.o_step_idx), 32'd3);

        // Reset mid-roll.
        run_roll(0, -1, -1, 12, -1, 1'b0);

        // Single-step instance.
        run_roll(1, -1, -1, -1, -2, 1'b0);
        chk("single step value", 32'(bus1.o_value), 32'd6);
        run_roll(1, 3, -1, -1, -1, 1'b0);

        // Randomized rolls, some with an early stop.
        for (int i = 0; i < 8; i++) begin
            s = ($urandom_range(2, 0) != 0) ? int'($urandom_range(30, 1)) : -1;
            run_roll(0, s, -1, -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/roll_scheduler.md
Name: roll_scheduler

Overview:
Sequences the 4-bit LFSR random generator for one "roll". Each roll issues NUM_STEPS single-cycle step pulses to the LFSR on a decelerating schedule; step k fires k prescaled ticks after step k-1. The block latches the LFSR output after every step, reports the final value, and keeps a shift-register history of the last HIST_DEPTH final results. It sits between the key-press debouncer and the LFSR, and replaces ad-hoc counter logic in the top level.

Parameters:
TICK_DIV, 2097152, clock cycles per tick; must be >= 4.
NUM_STEPS, 10, LFSR steps per roll; range 1..255.
HIST_DEPTH, 4, number of past final results kept.
DATA_W, 4, width of the random value.

Ports:
i_clk  input  1  clock, all logic on the rising edge
i_rst  input  1  synchronous, active-high reset
i_start  input  1  single-cycle start pulse (debounced key)
i_stop  input  1  single-cycle early-stop request
i_rand  input  DATA_W  current LFSR output
o_lfsr_step  output  1  single-cycle step request to the LFSR
o_busy  output  1  high while a roll is in progress
o_value  output  DATA_W  most recently latched LFSR value
o_done  output  1  single-cycle pulse when a roll completes
o_step_idx  output  8  steps completed in the current or last roll
o_hist  output  HIST_DEPTH*DATA_W  past final results, newest in bits [DATA_W-1:0]

Behaviour:
- Reset: i_clk and i_rst only; reset is synchronous and active-high. On reset all outputs are 0, state is IDLE, and the prescaler, tick count and history are cleared. Reset mid-roll aborts the roll with no o_done pulse.
- States: IDLE, WAIT, STEP, LATCH.
- IDLE:
  - o_busy=0.
  - i_start=1 -> WAIT next cycle; prescaler=0, tick_cnt=0, o_step_idx=0, stop_req=0.
  - i_stop is ignored in IDLE.
  - i_start and i_stop high in the same cycle in IDLE: start wins, stop is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps, running in WAIT, STEP and LATCH.
  - tick=1 in the cycle where prescaler==TICK_DIV-1.
  - Because TICK_DIV >= 4, a tick cannot coincide with STEP or LATCH.
- WAIT:
  - On each tick, tick_cnt increments.
  - When the tick brings tick_cnt to o_step_idx+1, go to STEP next cycle.
- STEP:
  - Lasts exactly 1 cycle with o_lfsr_step=1; o_lfsr_step is 0 in every other state.
  - tick_cnt resets to 0; go to LATCH.
- LATCH:
  - Lasts exactly 1 cycle; o_value <= i_rand at the end of the cycle.
  - o_step_idx increments at the same edge.
  - If the new o_step_idx == NUM_STEPS, or stop_req=1: go to IDLE. o_done=1 for the first IDLE cycle, o_busy=0, and the history shifts left by DATA_W with the new o_value inserted into the low bits. The oldest entry is discarded.
  - Otherwise go back to WAIT.
- Early stop: i_stop in WAIT, STEP or LATCH sets stop_req. The next LATCH completion ends the roll, including a LATCH in the same cycle as i_stop. o_step_idx then holds the count actually performed.
- i_start while busy is ignored; there is no restart.
- o_busy=1 in WAIT, STEP and LATCH.
- Step k fires k ticks after the previous step, so the last step falls at tick NUM_STEPS*(NUM_STEPS+1)/2 after the roll starts.
- o_value and o_hist hold their values between rolls. o_step_idx holds its value until the next start.

Test Plan:
(Use TICK_DIV=4, NUM_STEPS=3, HIST_DEPTH=4, DATA_W=4; cycle numbering from the edge that samples i_start=1 as cycle 0.)
1. Nominal roll, i_rand = cycle number mod 16:
   - Ticks fall at cycles 4, 8, 12, 16, 20, 24.
   - o_lfsr_step is high only at cycles 5, 13 and 25.
   - o_value becomes 6, then 14, then 10 (26 mod 16), visible from cycles 7, 15 and 27.
   - o_done=1 only at cycle 27; o_busy is high from cycle 1 to 26; o_step_idx=3.
2. History: four rolls with final values 1, 2, 3, 4 -> o_hist=16'h1234. A fifth roll ending with 5 -> 16'h2345.
3. Early stop: i_stop at cycle 9 -> o_lfsr_step at cycle 13 is the last step, o_done at cycle 15, o_step_idx=2, and o_hist takes the value latched at cycle 14.
4. Start while busy: i_start pulsed at cycle 10 -> timing identical to scenario 1, with no second roll. Start and stop together in IDLE -> normal full roll.
5. Reset mid-roll: i_rst high at cycle 12 -> cycle 13 shows all outputs 0, no o_lfsr_step at cycle 13, and no o_done.
6. NUM_STEPS=1 -> single step pulse at cycle 5 and o_done at cycle 7.
